// File: rtl/loba_pkg.sv
// Shared widths and state encoding for the LOBA product accumulator.
package loba_pkg;
  localparam int LOBA_P_W   = 32;
  localparam int LOBA_ACC_W = 40;
  localparam int LOBA_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } loba_state_e;
endpackage

// File: rtl/loba_prod_acc_if.sv
// Product stream in, group result out; slave side is the accumulator.
interface loba_prod_acc_if
  import loba_pkg::*;
#(
  parameter int P_W   = LOBA_P_W,
  parameter int ACC_W = LOBA_ACC_W,
  parameter int CNT_W = LOBA_CNT_W
);
  logic             in_valid;
  logic             in_ready;
  logic [P_W-1:0]   in_p;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
endinterface

// File: rtl/loba_sat_add.sv
// Unsigned W-bit add that clamps to all-ones on carry and reports the carry.
module loba_sat_add #(
  parameter int W = 40
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);
  logic [W:0] full_w;

  // Once a sum is all-ones any further add carries or adds zero, so it stays pinned.
  assign full_w  = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o = full_w[W];
  assign sum_o   = full_w[W] ? '1 : full_w[W-1:0];
endmodule

// File: rtl/loba_prod_acc.sv
// Saturating accumulator for a stream of approximate products, one result per group.
module loba_prod_acc
  import loba_pkg::*;
#(
  parameter int P_W   = LOBA_P_W,
  parameter int ACC_W = LOBA_ACC_W,
  parameter int CNT_W = LOBA_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  loba_prod_acc_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  loba_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_sum_q, out_sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_cnt_q, out_cnt_d;
  logic             ovf_q, ovf_d, out_ovf_q, out_ovf_d;
  logic [ACC_W-1:0] p_ext_w, sum_w;
  logic             carry_w, accept_w, first_w;

  assign p_ext_w       = ACC_W'(bus.in_p);
  // Ready depends only on registered state, never on out_ready.
  assign bus.in_ready  = (state_q != ST_HOLD);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_ovf   = out_ovf_q;
  assign accept_w      = bus.in_valid & bus.in_ready;
  // IDLE means no open group: the next beat restarts acc instead of adding stale data.
  assign first_w       = (state_q == ST_IDLE);

  loba_sat_add #(.W(ACC_W)) u_add (
    .a_i    (acc_q),
    .b_i    (p_ext_w),
    .sum_o  (sum_w),
    .carry_o(carry_w)
  );

  // Next state, running sum/count/overflow, and result capture on the last beat.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;
    if (accept_w) begin
      if (first_w) begin
        acc_d = p_ext_w;
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
      end else begin
        acc_d = sum_w;
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        ovf_d = ovf_q | carry_w;
      end
      if (bus.in_last) begin
        state_d   = ST_HOLD;
        out_sum_d = acc_d;
        out_cnt_d = cnt_d;
        out_ovf_d = ovf_d;
      end else begin
        state_d = ST_ACCUM;
      end
    end else if (state_q == ST_HOLD && bus.out_ready) begin
      state_d = ST_IDLE;
    end
  end

  // State and data registers; reset drops any partial group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end
endmodule

// File: tb/tb_loba_prod_acc.sv
// Three accumulators (default, 33-bit sum, 2-bit count) share one stimulus stream
// and are compared every cycle against a group-level reference model.
module tb_loba_prod_acc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_p = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  loba_prod_acc_if #(.P_W(32), .ACC_W(40), .CNT_W(8)) if0 ();
  loba_prod_acc_if #(.P_W(32), .ACC_W(33), .CNT_W(8)) if1 ();
  loba_prod_acc_if #(.P_W(32), .ACC_W(40), .CNT_W(2)) if2 ();

  assign if0.in_valid = in_valid; assign if0.in_p = in_p; assign if0.in_last = in_last; assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid; assign if1.in_p = in_p; assign if1.in_last = in_last; assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid; assign if2.in_p = in_p; assign if2.in_last = in_last; assign if2.out_ready = out_ready;

  loba_prod_acc #(.P_W(32), .ACC_W(40), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  loba_prod_acc #(.P_W(32), .ACC_W(33), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  loba_prod_acc #(.P_W(32), .ACC_W(40), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [63:0] osum [3];
  logic [63:0] ocnt [3];
  logic        oovf [3];
  logic        ordy [3];
  logic        ovld [3];
  assign osum[0] = 64'(if0.out_sum); assign ocnt[0] = 64'(if0.out_cnt); assign oovf[0] = if0.out_ovf;
  assign osum[1] = 64'(if1.out_sum); assign ocnt[1] = 64'(if1.out_cnt); assign oovf[1] = if1.out_ovf;
  assign osum[2] = 64'(if2.out_sum); assign ocnt[2] = 64'(if2.out_cnt); assign oovf[2] = if2.out_ovf;
  assign ordy[0] = if0.in_ready; assign ovld[0] = if0.out_valid;
  assign ordy[1] = if1.in_ready; assign ovld[1] = if1.out_valid;
  assign ordy[2] = if2.in_ready; assign ovld[2] = if2.out_valid;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a group is a list of terms; the result is the true sum
  // clamped to the width, overflow when the true sum exceeds it, count clamped.
  int          cfg_acc [3] = '{40, 33, 40};
  int          cfg_cnt [3] = '{8, 8, 2};
  bit          m_hold, m_grp;
  longint unsigned m_raw;
  int          m_n;
  logic [63:0] m_osum [3];
  logic [63:0] m_ocnt [3];
  bit          m_oovf [3];

  logic [31:0] q_p [$];
  bit          q_l [$];

  task automatic model_reset();
    m_hold = 0; m_grp = 0; m_raw = 0; m_n = 0;
    for (int k = 0; k < 3; k++) begin
      m_osum[k] = '0; m_ocnt[k] = '0; m_oovf[k] = 0;
    end
  endtask

  task automatic close_group();
    for (int k = 0; k < 3; k++) begin
      longint unsigned smax, cmax;
      smax = (64'd1 << cfg_acc[k]) - 64'd1;
      cmax = (64'd1 << cfg_cnt[k]) - 64'd1;
      m_osum[k] = (m_raw > smax) ? smax : m_raw;
      m_oovf[k] = (m_raw > smax);
      m_ocnt[k] = (64'(m_n) > cmax) ? cmax : 64'(m_n);
    end
  endtask

  // One clock: advance the model with the inputs present, then compare at negedge.
  task automatic step(output bit acc);
    bit rel;
    acc = !rst && in_valid && !m_hold;
    rel = !rst && m_hold && out_ready;
    @(posedge clk);
    if (rst) model_reset();
    else if (rel) m_hold = 0;
    else if (acc) begin
      if (!m_grp) begin m_raw = 0; m_n = 0; end
      m_raw += 64'(in_p);
      m_n++;
      m_grp = 1;
      if (in_last) begin
        m_hold = 1; m_grp = 0;
        close_group();
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("in_ready%0d", k), 64'(ordy[k]), 64'(!m_hold));
      chk($sformatf("out_valid%0d", k), 64'(ovld[k]), 64'(m_hold));
      chk($sformatf("out_sum%0d", k), osum[k], m_osum[k]);
      chk($sformatf("out_cnt%0d", k), ocnt[k], m_ocnt[k]);
      chk($sformatf("out_ovf%0d", k), 64'(oovf[k]), 64'(m_oovf[k]));
    end
  endtask

  task automatic push(input logic [31:0] p, input bit last);
    q_p.push_back(p); q_l.push_back(last);
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 stall five held cycles then ready.
  task automatic drain(input int rdy_mode, input bit gaps, input bit wait_res);
    int budget = 3000;
    int hold_cnt = 0;
    bit acc;
    while ((q_p.size() > 0 || (wait_res && m_hold)) && budget > 0) begin
      in_valid = (q_p.size() > 0) && (!gaps || $urandom_range(3) != 0);
      in_p     = (q_p.size() > 0) ? q_p[0] : $urandom;
      in_last  = (q_l.size() > 0) ? q_l[0] : 1'b0;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(1));
        default: out_ready = (hold_cnt >= 5);
      endcase
      step(acc);
      if (acc) begin void'(q_p.pop_front()); void'(q_l.pop_front()); end
      hold_cnt = m_hold ? hold_cnt + 1 : 0;
      budget--;
    end
    if (budget == 0) chk("drain_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    bit acc;
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'($urandom_range(1));
      in_p = $urandom;
      step(acc);
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset(2);

    // Partial group discarded by reset, then a single-beat group.
    push(32'd5, 0); push(32'd7, 0);
    drain(0, 0, 0);
    do_reset(1);
    push(32'd3, 1);
    drain(0, 0, 1);
    chk("rst_grp_sum", osum[0], 64'd3);
    chk("rst_grp_cnt", ocnt[0], 64'd1);

    // Basic three-term group.
    push(32'd100, 0); push(32'd200, 0); push(32'd300, 1);
    drain(0, 0, 1);
    chk("grp600_sum", osum[0], 64'd600);
    chk("grp600_cnt", ocnt[0], 64'd3);
    chk("grp600_ovf", 64'(oovf[0]), 64'd0);

    // Backpressure with the next group already waiting upstream.
    push(32'd11, 0); push(32'd22, 1); push(32'd44, 1);
    drain(2, 0, 1);

    // Overflow on the 33-bit instance.
    push(32'hFFFF_FFFF, 0); push(32'hFFFF_FFFF, 0); push(32'hFFFF_FFFF, 1);
    drain(0, 0, 1);
    chk("ovf33_sum", osum[1], 64'h1_FFFF_FFFF);
    chk("ovf33_ovf", 64'(oovf[1]), 64'd1);
    chk("ovf33_cnt", ocnt[1], 64'd3);
    chk("ovf40_sum", osum[0], 64'h2_FFFF_FFFD);

    // Counter saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) push(32'd1, i == 4);
    drain(0, 0, 1);
    chk("cnt2_cnt", ocnt[2], 64'd3);
    chk("cnt2_sum", osum[2], 64'd5);

    // Back-to-back groups with valid held high: 10 then 20.
    push(32'd1, 0); push(32'd2, 0); push(32'd3, 0); push(32'd4, 1);
    push(32'd5, 0); push(32'd15, 1);
    drain(0, 0, 1);
    chk("b2b_sum", osum[0], 64'd20);
    chk("b2b_cnt", ocnt[0], 64'd2);

    // Random groups, gaps, backpressure and occasional mid-group reset.
    for (int g = 0; g < 60; g++) begin
      int len;
      if ($urandom_range(9) == 0) begin
        push($urandom, 0);
        drain(1, 1, 0);
        do_reset(1);
      end
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++)
        push(($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(1000)), i == len - 1);
      drain(1, 1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
